// File: rtl/nios_system_pio_in_edge_pkg.sv
// Shared constants for the Nios II input PIO: register offsets and edge-type encodings.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package nios_pio_pkg;

   // Avalon register offsets
   localparam logic [1:0] PIO_DATA = 2'd0;
   localparam logic [1:0] PIO_RSVD = 2'd1;
   localparam logic [1:0] PIO_MASK = 2'd2;
   localparam logic [1:0] PIO_EDGE = 2'd3;

   // EDGE_TYPE parameter encodings
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_system_pio_in_edge_if.sv
// Avalon-MM slave bus bundle for the input PIO, plus its level interrupt.
// Latency: none (wiring only).
// Backpressure: none; the slave never stalls and has no waitrequest.
interface nios_system_pio_in_edge_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (output address, chipselect, write_n, writedata,
                   input  readdata, irq);
   modport slave  (input  address, chipselect, write_n, writedata,
                   output readdata, irq);
endinterface

// File: rtl/nios_system_pio_in_edge_debounce.sv
// One input bit: SYNC_STAGES-deep synchroniser followed by an optional stability debouncer.
// Latency: SYNC_STAGES edges without debounce, SYNC_STAGES+DEBOUNCE_CYCLES edges with it.
// Backpressure: none; free-running per-bit pipeline.
module pio_debounce_bit #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic in_i,
   output logic data_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_bit;

   // Shift the asynchronous input through the synchroniser chain
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
   end

   assign sync_bit = sync_q[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign data_o = sync_bit;
      end else begin : g_debounce
         localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

         logic [CW-1:0] cnt_q, cnt_d;
         logic          data_q, data_d;

         // Count consecutive cycles of disagreement; accept the new level once it has held long enough
         always_comb begin
            cnt_d  = '0;
            data_d = data_q;
            if (sync_bit != data_q) begin
               if (cnt_q == LAST) data_d = sync_bit;
               else               cnt_d  = cnt_q + CW'(1);
            end
         end

         // Debounce state; reset discards any pending change
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt_q  <= '0;
               data_q <= 1'b0;
            end else begin
               cnt_q  <= cnt_d;
               data_q <= data_d;
            end
         end

         assign data_o = data_q;
      end
   endgenerate

endmodule

// File: rtl/nios_system_pio_in_edge.sv
// Avalon-MM input PIO: synchronised/debounced inputs, sticky W1C edge capture, maskable level irq.
// Latency: registered readdata (1 cycle); irq combinational from capture and mask registers.
// Backpressure: none; every access completes in one cycle.
module nios_system_pio_in_edge
   import nios_pio_pkg::*;
#(
   parameter int WIDTH           = 1,
   parameter int EDGE_TYPE       = 0,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   nios_system_pio_in_edge_if.slave  bus,
   input  logic [WIDTH-1:0]          in_port
);

   logic [WIDTH-1:0] data_w;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] rise_w, fall_w, edge_w, clr_w;
   logic [31:0]      rd_q, rd_d;
   logic             wr_en;
   logic             unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .clk    (clk),
         .reset  (reset),
         .in_i   (in_port[i]),
         .data_o (data_w[i])
      );
   end

   assign wr_en        = bus.chipselect & ~bus.write_n;
   assign unused_wdata = ^bus.writedata;

   // Edge detection and register next-state; a new edge beats a same-cycle clear
   always_comb begin
      rise_w = data_w & ~prev_q;
      fall_w = ~data_w & prev_q;
      case (EDGE_TYPE)
         EDGE_FALL: edge_w = fall_w;
         EDGE_ANY:  edge_w = rise_w | fall_w;
         default:   edge_w = rise_w;
      endcase
      clr_w  = (wr_en && bus.address == PIO_EDGE) ? bus.writedata[WIDTH-1:0] : '0;
      cap_d  = (cap_q & ~clr_w) | edge_w;
      mask_d = (wr_en && bus.address == PIO_MASK) ? bus.writedata[WIDTH-1:0] : mask_q;
   end

   // Read mux; readdata reloads every cycle from the addressed register
   always_comb begin
      rd_d = '0;
      case (bus.address)
         PIO_DATA: rd_d = 32'(data_w);
         PIO_MASK: rd_d = 32'(mask_q);
         PIO_EDGE: rd_d = 32'(cap_q);
         default:  rd_d = '0;
      endcase
   end

   // Register file, previous-value flop and read register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_q <= '0;
         mask_q <= '0;
         cap_q  <= '0;
         rd_q   <= '0;
      end else begin
         prev_q <= data_w;
         mask_q <= mask_d;
         cap_q  <= cap_d;
         rd_q   <= rd_d;
      end
   end

   assign bus.readdata = rd_q;
   assign bus.irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_system_pio_in_edge.sv
// Directed bench for the input PIO: four instances (rise, any, fall, rise+debounce) on shared stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_nios_system_pio_in_edge;

   logic       clk;
   logic       reset;
   logic [3:0] in_port;
   int         checks;
   int         failures;

   nios_system_pio_in_edge_if if0 ();
   nios_system_pio_in_edge_if if1 ();
   nios_system_pio_in_edge_if if2 ();
   nios_system_pio_in_edge_if if3 ();

   nios_system_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0))
      dut_rise (.clk(clk), .reset(reset), .bus(if0), .in_port(in_port));
   nios_system_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0))
      dut_any  (.clk(clk), .reset(reset), .bus(if1), .in_port(in_port));
   nios_system_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0))
      dut_fall (.clk(clk), .reset(reset), .bus(if2), .in_port(in_port));
   nios_system_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4))
      dut_deb  (.clk(clk), .reset(reset), .bus(if3), .in_port(in_port));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic set_bus(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
      if0.address = a; if0.chipselect = cs; if0.write_n = wn; if0.writedata = wd;
      if1.address = a; if1.chipselect = cs; if1.write_n = wn; if1.writedata = wd;
      if2.address = a; if2.chipselect = cs; if2.write_n = wn; if2.writedata = wd;
      if3.address = a; if3.chipselect = cs; if3.write_n = wn; if3.writedata = wd;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      set_bus(a, 1'b1, 1'b0, d);
      tick();
      set_bus(a, 1'b0, 1'b1, 32'h0);
   endtask

   task automatic rd(input logic [1:0] a);
      set_bus(a, 1'b1, 1'b1, 32'h0);
      tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      in_port  = 4'b0000;
      set_bus(2'd0, 1'b0, 1'b1, 32'h0);

      // Reset / defaults
      tick(); tick();
      chk("reset_rdata", if0.readdata, 32'h0);
      chk("reset_irq",   {31'h0, if0.irq}, 32'h0);
      reset = 1'b0;
      tick();
      for (int a = 0; a < 4; a++) begin
         rd(2'(a));
         chk("defaults_read", if0.readdata, 32'h0);
      end
      chk("defaults_irq", {31'h0, if0.irq}, 32'h0);
      wr(2'd0, 32'hF);
      rd(2'd0);
      chk("data_ro", if0.readdata, 32'h0);
      wr(2'd1, 32'hFFFF_FFFF);
      rd(2'd1);
      chk("reserved_reads0", if0.readdata, 32'h0);

      // Rising capture and irq: bit 0 goes high, E0 is the next edge
      wr(2'd2, 32'h1);
      in_port = 4'b0001;
      tick();
      chk("rise_irq_E0", {31'h0, if0.irq}, 32'h0);
      tick();
      chk("rise_irq_E1", {31'h0, if0.irq}, 32'h0);
      tick();
      chk("rise_irq_E2", {31'h0, if0.irq}, 32'h1);
      chk("any_rise_irq_E2", {31'h0, if1.irq}, 32'h1);
      chk("fall_rise_irq_E2", {31'h0, if2.irq}, 32'h0);
      rd(2'd3);
      chk("rise_capture", if0.readdata, 32'h1);
      wr(2'd3, 32'h1);
      chk("w1c_irq_clear", {31'h0, if0.irq}, 32'h0);
      tick();
      chk("w1c_irq_next", {31'h0, if0.irq}, 32'h0);
      repeat (12) tick();
      wr(2'd3, 32'hF);

      // Masking: capture bit 2 with mask 0, then unmask
      wr(2'd2, 32'h0);
      in_port = 4'b0101;
      tick(); tick();
      in_port = 4'b0001;
      repeat (5) tick();
      rd(2'd3);
      chk("mask_capture", if0.readdata, 32'h4);
      chk("mask_irq_off", {31'h0, if0.irq}, 32'h0);
      wr(2'd2, 32'h4);
      chk("mask_irq_on", {31'h0, if0.irq}, 32'h1);
      repeat (12) tick();
      wr(2'd3, 32'hF);

      // Any-edge and falling-edge behaviour on bit 3
      wr(2'd2, 32'h8);
      in_port = 4'b1001;
      repeat (3) tick();
      chk("any_rise_irq", {31'h0, if1.irq}, 32'h1);
      chk("fall_on_rise_irq", {31'h0, if2.irq}, 32'h0);
      rd(2'd3);
      chk("any_rise_cap", if1.readdata, 32'h8);
      chk("fall_on_rise_cap", if2.readdata, 32'h0);
      wr(2'd3, 32'h8);
      chk("any_w1c_irq", {31'h0, if1.irq}, 32'h0);
      in_port = 4'b0001;
      repeat (3) tick();
      chk("any_fall_irq", {31'h0, if1.irq}, 32'h1);
      chk("fall_fall_irq", {31'h0, if2.irq}, 32'h1);
      repeat (12) tick();
      wr(2'd3, 32'hF);

      // Debounce: 3-cycle glitch on bit 1 is rejected
      wr(2'd2, 32'h2);
      in_port = 4'b0011;
      repeat (3) tick();
      in_port = 4'b0001;
      repeat (8) tick();
      chk("glitch_irq", {31'h0, if3.irq}, 32'h0);
      rd(2'd0);
      chk("glitch_data", if3.readdata, 32'h1);
      rd(2'd3);
      chk("glitch_cap", if3.readdata, 32'h0);

      // Debounce: 6-cycle high is accepted, data at E5 (visible in readdata after E6), capture at E6
      set_bus(2'd0, 1'b1, 1'b1, 32'h0);
      tick();
      in_port = 4'b0011;
      repeat (5) tick();
      chk("deb_data_E4", if3.readdata, 32'h1);
      chk("deb_irq_E4", {31'h0, if3.irq}, 32'h0);
      tick();
      chk("deb_data_E5", if3.readdata, 32'h1);
      chk("deb_irq_E5", {31'h0, if3.irq}, 32'h0);
      in_port = 4'b0001;
      tick();
      chk("deb_data_E6", if3.readdata, 32'h3);
      chk("deb_irq_E6", {31'h0, if3.irq}, 32'h1);

      // Clear/set collision on bit 0
      wr(2'd2, 32'h1);
      in_port = 4'b0000;
      repeat (12) tick();
      wr(2'd3, 32'hF);
      in_port = 4'b0001;
      tick(); tick();
      wr(2'd3, 32'h1);
      chk("collide_irq", {31'h0, if0.irq}, 32'h1);
      rd(2'd3);
      chk("collide_cap", if0.readdata, 32'h1);

      // Reset in the middle of a debounce window
      in_port = 4'b0101;
      repeat (3) tick();
      reset = 1'b1;
      #1;
      chk("rst_mid_irq0", {31'h0, if0.irq}, 32'h0);
      chk("rst_mid_irq3", {31'h0, if3.irq}, 32'h0);
      chk("rst_mid_rd0", if0.readdata, 32'h0);
      chk("rst_mid_rd3", if3.readdata, 32'h0);
      in_port = 4'b0000;
      tick(); tick();
      reset = 1'b0;
      repeat (6) tick();
      rd(2'd0);
      chk("rst_mid_data", if3.readdata, 32'h0);
      rd(2'd2);
      chk("rst_mid_mask", if0.readdata, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
